tone_sequencer: RTL and testbench

- Sequences a squaregen tone generator through a short melody held in an internal note table.
- Each note has a period and a duration. Notes are separated by a fixed silent gap.
- Drives squaregen's period and en inputs directly. Sits between the control/register logic and the tone datapath.
- Supports single-shot or looped playback, plus immediate stop.

---
 rtl/tone_pkg.sv | 27 ++
 rtl/tone_sequencer_tick_prescaler.sv | 36 +++
 rtl/tone_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pkg
//  Description : Shared types for the tone sequencer: FSM state encoding,
//                squaregen period width and the note-table entry view.
//  Revision    : 1.0  initial release
// ============================================================================
package tone_pkg;

    localparam int PERIOD_W  = 23;
    // Widest duration the note view can carry; the table itself stores DUR_W.
    localparam int DUR_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0]  period;
        logic [DUR_W_MAX-1:0] dur;
    } note_t;

endpackage
`default_nettype wire

// File: rtl/tone_sequencer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk by TICK_DIV into a one-cycle tick pulse. A clear
//                restarts the count so the next tick lands TICK_DIV cycles on.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 48000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running 0..TICK_DIV-1 counter, forced back to 0 by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = !clr && (r_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Plays the melody held in an internal note table through a
//                squaregen tone generator: per-note period and duration,
//                fixed silent gap between notes, single-shot or looped.
//  Revision    : 1.0  initial release
// ============================================================================
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 48000,
    parameter int GAP_TICKS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DUR_W-1:0]    wr_dur,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                loop,
    input  logic                start,
    input  logic                stop,
    output logic [PERIOD_W-1:0] period,
    output logic                tone_en,
    output logic                busy,
    output logic [ADDR_W-1:0]   step_idx,
    output logic                done
);

    // Gap counter keeps at least one bit so a zero-gap build still elaborates.
    localparam int               GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [PERIOD_W-1:0] r_tab_period [DEPTH];
    logic [DUR_W-1:0]    r_tab_dur    [DEPTH];

    state_t              r_state,    w_state_nx;
    logic [PERIOD_W-1:0] r_period,   w_period_nx;
    logic [ADDR_W-1:0]   r_step_idx, w_step_nx;
    logic [ADDR_W-1:0]   r_last_idx, w_last_nx;
    logic [DUR_W-1:0]    r_dur,      w_dur_nx;
    logic [GAP_W-1:0]    r_gap,      w_gap_nx;
    logic                r_tone_en;
    logic                r_busy;
    logic                r_done,     w_done_nx;

    note_t               w_entry;
    logic                w_tick;
    logic                w_clr;
    state_t              w_adv_state;
    logic [ADDR_W-1:0]   w_adv_step;
    logic                w_adv_done;

    // Every LOAD restarts the prescaler so notes and gaps begin on a tick boundary.
    assign w_clr = (r_state == LOAD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Note table: plain registers, never reset, writable at any time.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tab_period[wr_addr] <= wr_period;
            r_tab_dur[wr_addr]    <= wr_dur;
        end
    end

    // Read view of the current entry; a same-cycle write is seen next cycle.
    always_comb begin
        w_entry        = '0;
        w_entry.period = r_tab_period[r_step_idx];
        w_entry.dur    = DUR_W_MAX'(r_tab_dur[r_step_idx]);
    end

    // Where playback goes once the current entry (note + gap) is finished.
    always_comb begin
        w_adv_state = LOAD;
        w_adv_step  = r_step_idx + ADDR_W'(1);
        w_adv_done  = 1'b0;
        if (r_step_idx == r_last_idx) begin
            w_adv_step = '0;
            if (!loop) begin
                w_adv_state = IDLE;
                w_adv_step  = r_step_idx;
                w_adv_done  = 1'b1;
            end
        end
    end

    // Next-state and next-register logic; stop overrides everything.
    always_comb begin
        w_state_nx  = r_state;
        w_period_nx = r_period;
        w_step_nx   = r_step_idx;
        w_last_nx   = r_last_idx;
        w_dur_nx    = r_dur;
        w_gap_nx    = r_gap;
        w_done_nx   = 1'b0;
        if (stop) begin
            w_state_nx = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nx = LOAD;
                        w_step_nx  = '0;
                        w_last_nx  = last_idx;
                    end
                end
                LOAD: begin
                    if (w_entry.dur == '0) begin
                        w_state_nx = w_adv_state;
                        w_step_nx  = w_adv_step;
                        w_done_nx  = w_adv_done;
                    end else begin
                        w_state_nx  = PLAY;
                        w_period_nx = w_entry.period;
                        w_dur_nx    = w_entry.dur[DUR_W-1:0];
                    end
                end
                PLAY: begin
                    if (w_tick) begin
                        w_dur_nx = r_dur - DUR_W'(1);
                        if (r_dur == DUR_W'(1)) begin
                            if (GAP_TICKS == 0) begin
                                w_state_nx = w_adv_state;
                                w_step_nx  = w_adv_step;
                                w_done_nx  = w_adv_done;
                            end else begin
                                w_state_nx = GAP;
                                w_gap_nx   = '0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        if (r_gap == GAP_LAST) begin
                            w_state_nx = w_adv_state;
                            w_step_nx  = w_adv_step;
                            w_done_nx  = w_adv_done;
                        end else begin
                            w_gap_nx = r_gap + GAP_W'(1);
                        end
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // State and output registers; tone_en/busy follow the next state in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_period   <= '0;
            r_step_idx <= '0;
            r_last_idx <= '0;
            r_dur      <= '0;
            r_gap      <= '0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_period   <= w_period_nx;
            r_step_idx <= w_step_nx;
            r_last_idx <= w_last_nx;
            r_dur      <= w_dur_nx;
            r_gap      <= w_gap_nx;
            r_tone_en  <= (w_state_nx == PLAY) && (w_period_nx != '0);
            r_busy     <= (w_state_nx != IDLE);
            r_done     <= w_done_nx;
        end
    end

    assign period   = r_period;
    assign tone_en  = r_tone_en;
    assign busy     = r_busy;
    assign step_idx = r_step_idx;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_sequencer
//  Description : Directed self-checking bench for tone_sequencer with
//                TICK_DIV=4 and GAP_TICKS=2 (note = dur*4 cycles, gap = 8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tone_sequencer;

    localparam int ADDR_W = 4;
    localparam int DUR_W  = 16;
    localparam int LIMIT  = 500;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [22:0]       wr_period;
    logic [DUR_W-1:0]  wr_dur;
    logic [ADDR_W-1:0] last_idx;
    logic              loop;
    logic              start;
    logic              stop;
    logic [22:0]       period;
    logic              tone_en;
    logic              busy;
    logic [ADDR_W-1:0] step_idx;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done_seen = 0;

    tone_sequencer #(
        .DEPTH     (16),
        .ADDR_W    (ADDR_W),
        .DUR_W     (DUR_W),
        .TICK_DIV  (4),
        .GAP_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_dur    (wr_dur),
        .last_idx  (last_idx),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .tone_en   (tone_en),
        .busy      (busy),
        .step_idx  (step_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Count done pulses across the whole run.
    always @(posedge clk) begin
        if (done) n_done_seen <= n_done_seen + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_entry(input int a, input int p, input int d);
        wr_en     = 1'b1;
        wr_addr   = ADDR_W'(a);
        wr_period = 23'(p);
        wr_dur    = DUR_W'(d);
        @(negedge clk);
        wr_en     = 1'b0;
    endtask

    // Pulse start for one edge; returns in the LOAD cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Number of consecutive cycles tone_en holds its current level.
    task automatic run_len(output int n);
        logic v;
        v = tone_en;
        n = 0;
        while (tone_en == v && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Cycles until done is seen high (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;
    int d0;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
        last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check_val("rst_period",  32'(period),   0);
        check_val("rst_tone_en", 32'(tone_en),  0);
        check_val("rst_busy",    32'(busy),     0);
        check_val("rst_done",    32'(done),     0);
        check_val("rst_step",    32'(step_idx), 0);

        // ---- single-shot pass ----
        write_entry(0, 100, 3);
        write_entry(1, 200, 2);
        last_idx = 4'd1; loop = 1'b0;
        pulse_start();
        check_val("ss_load_busy", 32'(busy), 1);
        check_val("ss_load_tone", 32'(tone_en), 0);
        cyc(1);
        check_val("ss_n0_tone",   32'(tone_en), 1);
        check_val("ss_n0_period", 32'(period), 100);
        check_val("ss_n0_step",   32'(step_idx), 0);
        run_len(n);  check_val("ss_n0_high", 32'(n), 12);
        run_len(n);  check_val("ss_gap0_low", 32'(n), 9);
        check_val("ss_n1_period", 32'(period), 200);
        check_val("ss_n1_step",   32'(step_idx), 1);
        run_len(n);  check_val("ss_n1_high", 32'(n), 8);
        wait_done(n); check_val("ss_done_wait", 32'(n), 8);
        check_val("ss_done_busy", 32'(busy), 0);
        cyc(1);
        check_val("ss_done_pulse", 32'(done), 0);
        check_val("ss_done_count", 32'(n_done_seen), 1);

        // ---- rest and skip entries ----
        write_entry(0, 0, 2);
        write_entry(1, 50, 0);
        write_entry(2, 75, 1);
        last_idx = 4'd2;
        pulse_start();
        cyc(1);
        check_val("rs_rest_busy",   32'(busy), 1);
        check_val("rs_rest_tone",   32'(tone_en), 0);
        check_val("rs_rest_period", 32'(period), 0);
        cyc(16);
        check_val("rs_skip_step",   32'(step_idx), 1);
        cyc(1);
        check_val("rs_after_skip_step",   32'(step_idx), 2);
        check_val("rs_after_skip_period", 32'(period), 0);
        check_val("rs_after_skip_tone",   32'(tone_en), 0);
        cyc(1);
        check_val("rs_n2_tone",   32'(tone_en), 1);
        check_val("rs_n2_period", 32'(period), 75);
        run_len(n);   check_val("rs_n2_high", 32'(n), 4);
        wait_done(n); check_val("rs_done_wait", 32'(n), 8);
        cyc(1);

        // ---- looping ----
        write_entry(0, 10, 1);
        last_idx = 4'd0; loop = 1'b1;
        d0 = n_done_seen;
        pulse_start();
        cyc(1);
        run_len(n);  check_val("lp_high1", 32'(n), 4);
        run_len(n);  check_val("lp_low1",  32'(n), 9);
        check_val("lp_step", 32'(step_idx), 0);
        run_len(n);  check_val("lp_high2", 32'(n), 4);
        run_len(n);  check_val("lp_low2",  32'(n), 9);
        check_val("lp_no_done", 32'(n_done_seen - d0), 0);
        loop = 1'b0;
        run_len(n);   check_val("lp_high3", 32'(n), 4);
        wait_done(n); check_val("lp_done_wait", 32'(n), 8);
        cyc(1);
        check_val("lp_done_count", 32'(n_done_seen - d0), 1);

        // ---- stop mid-PLAY ----
        write_entry(0, 100, 3);
        d0 = n_done_seen;
        pulse_start();
        cyc(1);
        check_val("st_playing", 32'(tone_en), 1);
        cyc(3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("st_tone", 32'(tone_en), 0);
        check_val("st_busy", 32'(busy), 0);
        cyc(3);
        check_val("st_no_done", 32'(n_done_seen - d0), 0);

        // ---- start and stop together from IDLE ----
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("ss_stop_busy", 32'(busy), 0);
            @(negedge clk);
        end

        // ---- start while busy and live write ----
        write_entry(0, 100, 1);
        write_entry(1, 200, 1);
        last_idx = 4'd1;
        pulse_start();
        cyc(1);
        start = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd1; wr_period = 23'd300; wr_dur = 16'd2;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check_val("sb_tone",   32'(tone_en), 1);
        check_val("sb_step",   32'(step_idx), 0);
        check_val("sb_period", 32'(period), 100);
        run_len(n);  check_val("sb_n0_rest_high", 32'(n), 3);
        run_len(n);  check_val("sb_gap_low", 32'(n), 9);
        check_val("sb_new_period", 32'(period), 300);
        check_val("sb_new_step",   32'(step_idx), 1);
        run_len(n);  check_val("sb_new_high", 32'(n), 8);
        wait_done(n); check_val("sb_done_wait", 32'(n), 8);
        cyc(1);

        // ---- asynchronous reset mid-GAP ----
        write_entry(0, 100, 1);
        last_idx = 4'd0;
        pulse_start();
        cyc(7);
        check_val("ar_in_gap_busy", 32'(busy), 1);
        check_val("ar_in_gap_tone", 32'(tone_en), 0);
        #1 rst_n = 1'b0;
        #1;
        check_val("ar_period", 32'(period),   0);
        check_val("ar_busy",   32'(busy),     0);
        check_val("ar_tone",   32'(tone_en),  0);
        check_val("ar_step",   32'(step_idx), 0);
        check_val("ar_done",   32'(done),     0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(10);
        check_val("ar_idle_busy", 32'(busy), 0);
        check_val("ar_idle_tone", 32'(tone_en), 0);
        pulse_start();
        cyc(1);
        check_val("ar_restart_tone",   32'(tone_en), 1);
        check_val("ar_restart_period", 32'(period), 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
